rock_sequencer: RTL and testbench

Sequencer that drives the frequency/amplitude register block (F, A, 3-bit each, reset to 5) of the baby rocker. It watches the synchronised crying input, raises rocking frequency while crying persists, then walks frequency and amplitude down once the baby is quiet. When both reach zero it reinitialises the register block. It issues the `Fhoog`/`Flaag`/`Alaag` step strobes and the register-block reset, and guarantees that F never wraps.

---
 rtl/rock_sequencer.sv | 120 ++++++++++++
 tb/tb_rock_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rock_sequencer.sv
// Baby-rocker sequencer: climbs rocking frequency while the baby cries, then
// walks F and A down to zero, reinitialises the F/A register block and idles.
module rock_sequencer #(
  parameter int unsigned STEP_CYCLES = 1000,
  parameter int unsigned QUIET_TICKS = 8,
  parameter int unsigned F_MAX       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       huil,
  input  logic [2:0] F,
  input  logic [2:0] A,
  input  logic       F0,
  input  logic       AF0,
  output logic       Fhoog,
  output logic       Flaag,
  output logic       Alaag,
  output logic       fag_rst,
  output logic       motor_en,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROCK = 3'd1,
    S_CALM = 3'd2,
    S_FADE = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int unsigned    CW         = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]  TICK_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [7:0]     QUIET_LIM  = 8'(QUIET_TICKS);

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    quiet_q, quiet_inc;
  logic          fhoog_d, flaag_d, alaag_d, fag_rst_d;
  logic          state_change, rock_entry;

  assign tick         = (tick_cnt == TICK_LAST);
  assign quiet_inc    = (quiet_q == 8'hFF) ? quiet_q : quiet_q + 8'd1;
  assign state_change = (state_d != state_q);
  assign rock_entry   = (state_d == S_ROCK) && (state_q != S_ROCK);
  assign state        = state_q;

  // State register together with the registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge values regardless of process ordering.
      state_q <= S_IDLE;
      Fhoog   <= 1'b0;
      Flaag   <= 1'b0;
      Alaag   <= 1'b0;
      fag_rst <= 1'b0;
    end else begin
      state_q <= state_d;
      Fhoog   <= fhoog_d;
      Flaag   <= flaag_d;
      Alaag   <= alaag_d;
      fag_rst <= fag_rst_d;
    end
  end

  // Next-state logic; only IDLE and DONE move without waiting for a tick.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (huil) state_d = S_ROCK;
      S_ROCK: if (tick && !huil && (quiet_inc == QUIET_LIM)) state_d = S_CALM;
      S_CALM: if (tick) begin
        if (huil)    state_d = S_ROCK;
        else if (F0) state_d = S_FADE;
      end
      S_FADE: if (tick) begin
        if (huil)     state_d = S_ROCK;
        else if (AF0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode. The explicit F/A value guards keep the register block from
  // wrapping even if F_MAX or the flag inputs disagree with F and A.
  always_comb begin
    fhoog_d   = 1'b0;
    flaag_d   = 1'b0;
    alaag_d   = 1'b0;
    fag_rst_d = (state_d == S_DONE);
    motor_en  = (state_q == S_ROCK) || (state_q == S_CALM) || (state_q == S_FADE);
    if (tick) begin
      case (state_q)
        S_ROCK:  fhoog_d = huil && (32'(F) < F_MAX) && (F != 3'd7);
        S_CALM:  flaag_d = !huil && !F0 && (F != 3'd0);
        S_FADE:  alaag_d = !huil && !AF0 && (A != 3'd0);
        default: ;
      endcase
    end
  end

  // Decision tick: restarts on every state change so each state gets a full period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    tick_cnt <= '0;
    else if (tick || state_change) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              quiet_q <= 8'd0;
    else if (rock_entry)                     quiet_q <= 8'd0;
    else if (tick && huil)                   quiet_q <= 8'd0;
    else if (tick && (state_q == S_ROCK))    quiet_q <= quiet_inc;
  end

endmodule

// File: tb/tb_rock_sequencer.sv
// Bench for rock_sequencer: F/A register model, cycle predictor feeding a
// scoreboard queue, a directed step table and hand-written corner sequences.
module tb_rock_sequencer;

  localparam int S  = 4;
  localparam int Q  = 2;
  localparam int FM = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       huil;
  logic [2:0] f_reg, a_reg;
  logic       f0, af0;
  logic       fhoog, flaag, alaag, fag_rst, motor_en;
  logic [2:0] state;

  rock_sequencer #(.STEP_CYCLES(S), .QUIET_TICKS(Q), .F_MAX(FM)) dut (
    .clk(clk), .reset(rst_n), .huil(huil), .F(f_reg), .A(a_reg), .F0(f0), .AF0(af0),
    .Fhoog(fhoog), .Flaag(flaag), .Alaag(alaag), .fag_rst(fag_rst),
    .motor_en(motor_en), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_fh = 0, n_fl = 0, n_al = 0, n_rs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Register block model: updates one cycle after each strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || fag_rst) begin
      f_reg <= 3'd5;
      a_reg <= 3'd5;
    end else begin
      if (fhoog) f_reg <= f_reg + 3'd1;
      if (flaag) f_reg <= f_reg - 3'd1;
      if (alaag) a_reg <= a_reg - 3'd1;
    end
  end
  assign f0  = (f_reg == 3'd0);
  assign af0 = (f_reg == 3'd0) && (a_reg == 3'd0);

  typedef struct packed {
    logic [2:0] st;
    logic       motor;
    logic       fh, fl, al, rs;
  } outs_t;

  outs_t sb[$];

  // Predictor: per clock, derive the outputs that must appear after this edge.
  int    m_state = 0, m_cnt = 0, m_quiet = 0, m_ns;
  bit    m_tick_prev = 0, m_tk;
  outs_t m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_quiet = 0; m_tick_prev = 0;
      sb.delete();
    end else begin
      m_tk = (m_cnt == S - 1);
      m_ns = m_state;
      m_e  = '0;
      case (m_state)
        0: if (huil) m_ns = 1;
        1: if (m_tk) begin
          if (huil) m_e.fh = (f_reg < 3'(FM)) && (f_reg != 3'd7);
          else begin
            if (m_quiet < 255) m_quiet++;
            if (m_quiet == Q) m_ns = 2;
          end
        end
        2: if (m_tk) begin
          if (huil)                m_ns = 1;
          else if (f_reg != 3'd0)  m_e.fl = 1'b1;
          else                     m_ns = 3;
        end
        3: if (m_tk) begin
          if (huil)                                  m_ns = 1;
          else if (f_reg == 3'd0 && a_reg == 3'd0)   m_ns = 4;
          else if (a_reg != 3'd0)                    m_e.al = 1'b1;
        end
        default: m_ns = 0;
      endcase
      if ((m_ns == 1 && m_state != 1) || (m_tk && huil)) m_quiet = 0;
      m_cnt       = (m_tk || m_ns != m_state) ? 0 : m_cnt + 1;
      m_state     = m_ns;
      m_e.rs      = (m_ns == 4);
      m_e.st      = 3'(m_ns);
      m_e.motor   = (m_ns >= 1 && m_ns <= 3);
      m_tick_prev = m_tk;
      sb.push_back(m_e);
    end
  end

  // Monitor: pop and compare away from the active edge, plus invariants.
  outs_t act, exp_o;
  always @(negedge clk) begin
    act = {state, motor_en, fhoog, flaag, alaag, fag_rst};
    if (!rst_n) check("reset_outs", 32'(act), 32'd0);
    else if (sb.size() > 0) begin
      exp_o = sb.pop_front();
      check("cycle_outs", 32'(act), 32'(exp_o));
    end
    if (fhoog) check("fhoog_at_f7", 32'(f_reg == 3'd7), 32'd0);
    if (flaag) check("flaag_at_f0", 32'(f_reg == 3'd0), 32'd0);
    if (alaag) check("alaag_at_a0", 32'(a_reg == 3'd0), 32'd0);
    if (fhoog | flaag | alaag | fag_rst) begin
      check("strobe_excl", 32'($countones({fhoog, flaag, alaag, fag_rst})), 32'd1);
      check("strobe_after_tick", 32'(m_tick_prev), 32'd1);
    end
    if (rst_n) begin
      n_fh += int'(fhoog); n_fl += int'(flaag); n_al += int'(alaag); n_rs += int'(fag_rst);
    end
  end

  typedef struct {
    bit         huil;
    int         cycles;
    logic [2:0] st, f, a;
    int         fh, fl, al, rs;
  } step_t;

  step_t steps[4];
  bit    found;
  int    left, len;

  initial begin
    steps[0] = '{1'b0, 20, 3'd0, 3'd5, 3'd5, 0, 0, 0, 0};  // quiet after reset
    steps[1] = '{1'b1, 30, 3'd1, 3'd7, 3'd5, 2, 0, 0, 0};  // climb and cap at 7
    steps[2] = '{1'b0, 80, 3'd0, 3'd5, 3'd5, 0, 7, 5, 1};  // full wind-down
    steps[3] = '{1'b1, 30, 3'd1, 3'd7, 3'd5, 2, 0, 0, 0};  // climb again from IDLE

    rst_n = 1'b0;
    huil  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_motor", 32'(motor_en), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      huil = steps[i].huil;
      n_fh = 0; n_fl = 0; n_al = 0; n_rs = 0;
      repeat (steps[i].cycles) @(posedge clk);
      #1;
      check($sformatf("step%0d_state", i), 32'(state), 32'(steps[i].st));
      check($sformatf("step%0d_f", i), 32'(f_reg), 32'(steps[i].f));
      check($sformatf("step%0d_a", i), 32'(a_reg), 32'(steps[i].a));
      check($sformatf("step%0d_fhoog", i), 32'(n_fh), 32'(steps[i].fh));
      check($sformatf("step%0d_flaag", i), 32'(n_fl), 32'(steps[i].fl));
      check($sformatf("step%0d_alaag", i), 32'(n_al), 32'(steps[i].al));
      check($sformatf("step%0d_fag_rst", i), 32'(n_rs), 32'(steps[i].rs));
    end

    // Re-cry in FADE at A=3, raised exactly in a tick cycle.
    huil  = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #1;
      if (m_state == 3 && a_reg == 3'd3 && m_cnt == S - 1) found = 1'b1;
    end
    check("fade_a3_reached", 32'(found), 32'd1);
    huil = 1'b1;
    @(posedge clk); #1;
    check("recry_state", 32'(state), 32'd1);
    check("recry_no_alaag", 32'(alaag), 32'd0);
    check("recry_quiet", 32'(dut.quiet_q), 32'd0);
    @(posedge clk); #1;
    check("recry_a_kept", 32'(a_reg), 32'd3);

    // Reset in the cycle a Flaag is due in CALM.
    repeat (20) @(posedge clk);
    #1;
    huil  = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (m_state == 2 && m_cnt == S - 1 && f_reg != 3'd0) found = 1'b1;
    end
    check("calm_flaag_due", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_motor", 32'(motor_en), 32'd0);
    n_fl = 0;
    repeat (2) begin
      @(posedge clk); #1;
      check("midrst_no_flaag", 32'(flaag), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_flaag", 32'(flaag), 32'd0);
    check("after_rst_state", 32'(state), 32'd0);

    // Random crying; the scoreboard and invariants check every cycle.
    left = 10000;
    while (left > 0) begin
      len  = int'($urandom_range(1, 60));
      huil = 1'($urandom_range(0, 1));
      repeat (len) @(posedge clk);
      #1;
      left -= len;
    end
    huil = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("final_idle", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got timeout, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
